fifo_sr_drain: RTL and testbench
================================

Name: fifo_sr_drain

Overview:
- Read-side controller for the shared-RAM multi-flux FIFO.
- Watches the per-flux empty flags and issues one-hot read strobes under round-robin arbitration.
- Captures the tagged FIFO output into one output register per flux, each with a valid/ready handshake to its downstream consumer.
- Checks that the tag on the returned word matches the granted flux, and counts words drained.

Parameters:
DATA_WIDTH, 8, payload width (the FIFO word without its tag).
FLUX, 2, number of fluxes; must be at least 2.
CNT_WIDTH, 16, width of the drained-word counter.
TAG_WIDTH, $clog2(FLUX), derived; tag width.
WIDTH, DATA_WIDTH+TAG_WIDTH, derived; FIFO word width.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
en  in  1  drain enable; 0 blocks all new reads.
fifo_empty  in  FLUX  per-flux empty flags from the FIFO.
fifo_dout  in  WIDTH  FIFO output {tag, data}; valid combinationally in the cycle fifo_read is asserted.
fifo_read  out  FLUX  one-hot read strobe to the FIFO; all zeros means no read.
m_valid  out  FLUX  per-flux output valid.
m_ready  in  FLUX  per-flux consumer ready.
m_data  out  FLUX*DATA_WIDTH  flattened per-flux payloads; flux f occupies bits [f*DATA_WIDTH +: DATA_WIDTH].
tag_err  out  1  sticky tag-mismatch flag.
rd_count  out  CNT_WIDTH  total words read, wrapping.

Behaviour:
Reset:
- rst=1 at a clock edge clears m_valid, m_data, tag_err, rd_count and the round-robin pointer rr_ptr.
- fifo_read is forced to 0 while rst=1. This also applies to reset asserted mid-stream: words held in slots are discarded.

Eligibility and grant (combinational, same cycle):
- slot_free[f] = !m_valid[f] | m_ready[f]. A slot being emptied this cycle can be refilled, so one flux sustains one word per cycle.
- elig[f] = en & !rst & !fifo_empty[f] & slot_free[f].
- Grant g is the first eligible flux searching upward from rr_ptr and wrapping from FLUX-1 to 0.
- fifo_read = onehot(g) if any flux is eligible, else 0.
- At most one bit of fifo_read is ever set, and never for a flux whose empty flag is 1.

Capture (next edge, grant g present):
- m_data[g] <= fifo_dout[DATA_WIDTH-1:0].
- m_valid[g] <= 1.
- rr_ptr <= (g==FLUX-1) ? 0 : g+1. Non-power-of-two FLUX wraps explicitly.
- rd_count <= rd_count+1, wrapping modulo 2^CNT_WIDTH.
- If fifo_dout[WIDTH-1 -: TAG_WIDTH] != g, then tag_err <= 1. The payload is still delivered.

Handshake:
- For every flux f other than the granted one: if m_valid[f] & m_ready[f], then m_valid[f] <= 0 (data is don't-care after this).
- While m_valid[f]=1 and m_ready[f]=0, m_data[f] is held stable.
- m_valid[f] never drops without a transfer, except on reset.

No grant:
- rr_ptr, rd_count and tag_err hold.
- Slots still drain normally through the handshake.

en=0:
- fifo_read=0 in the same cycle.
- Existing slots keep handshaking and draining.

tag_err:
- Stays at 1 until reset.

Latency:
- One cycle from fifo_read to m_valid.
- Throughput is one word per cycle aggregate.
- Fairness: a continuously eligible flux is granted within FLUX cycles.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with fifo_empty=2'b00 and en=1 -> fifo_read=0, m_valid=0, m_data=0, tag_err=0, rd_count=0 throughout.
2. Single word: FLUX=2, fifo_empty=2'b01, dout={1'b1,8'hA5}, m_ready=2'b11 -> fifo_read=2'b10 that cycle; next cycle m_valid=2'b10, m_data[15:8]=8'hA5, rd_count=1.
3. Round robin: both fluxes non-empty, all ready, dout tag tracking the grant -> fifo_read sequence 01,10,01,10; rd_count=4 after 4 cycles; tag_err=0.
4. Backpressure: m_ready[0]=0 after flux 0 receives 8'h11 -> no further fifo_read[0] while m_valid[0]=1 and m_data[7:0]=8'h11 is held; flux 1 is granted every cycle. Raise m_ready[0] -> flux 0 read resumes in the same cycle.
5. Tag mismatch: grant flux 0 with dout tag=1 -> tag_err=1 on the next cycle and stays 1 after correct-tag traffic; clears only on rst.
6. Enable/reset mid-stream: en=0 -> fifo_read=0 immediately and held slots still drain. Assert rst with m_valid=2'b11 -> next cycle m_valid=0 and rd_count=0.

Source files
------------

// File: rtl/fifo_sr_drain.sv
// Read-side controller for the shared-RAM multi-flux FIFO.
// Round-robin arbitrates non-empty fluxes whose output slot can accept a word,
// issues a one-hot read strobe, and captures the returned word into that
// flux's output register. Also flags tag mismatches and counts drained words.
module fifo_sr_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FLUX       = 2,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH  = $clog2(FLUX),
  parameter int unsigned WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [FLUX-1:0]            fifo_empty,
  input  logic [WIDTH-1:0]           fifo_dout,
  output logic [FLUX-1:0]            fifo_read,
  output logic [FLUX-1:0]            m_valid,
  input  logic [FLUX-1:0]            m_ready,
  output logic [FLUX*DATA_WIDTH-1:0] m_data,
  output logic                       tag_err,
  output logic [CNT_WIDTH-1:0]       rd_count
);

  logic [FLUX-1:0]            m_valid_q, m_valid_d;
  logic [FLUX*DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                       tag_err_q, tag_err_d;
  logic [CNT_WIDTH-1:0]       rd_count_q, rd_count_d;
  logic [TAG_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;

  logic [FLUX-1:0]      slot_free;
  logic [FLUX-1:0]      elig;
  logic                 grant_valid;
  logic [TAG_WIDTH-1:0] grant_idx;

  // A slot emptied this cycle may be refilled in the same cycle.
  assign slot_free = ~m_valid_q | m_ready;
  assign elig      = {FLUX{en & ~rst}} & ~fifo_empty & slot_free;

  // Round-robin search: first eligible flux at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < FLUX; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= FLUX) begin
        idx = idx - FLUX;
      end
      if (!grant_valid && elig[TAG_WIDTH'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = TAG_WIDTH'(idx);
      end
    end
  end

  // One-hot read strobe for the granted flux.
  always_comb begin
    fifo_read = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      if (grant_valid && (grant_idx == TAG_WIDTH'(f))) begin
        fifo_read[f] = 1'b1;
      end
    end
  end

  // Next state: handshake drains, grant capture, pointer/counter/error updates.
  always_comb begin
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    tag_err_d  = tag_err_q;
    rd_count_d = rd_count_q;
    rr_ptr_d   = rr_ptr_q;
    for (int unsigned f = 0; f < FLUX; f++) begin
      if (m_valid_q[f] && m_ready[f]) begin
        m_valid_d[f] = 1'b0;
      end
      // Capture wins over the drain so a slot can turn over every cycle.
      if (grant_valid && (grant_idx == TAG_WIDTH'(f))) begin
        m_valid_d[f]                             = 1'b1;
        m_data_d[f*DATA_WIDTH +: DATA_WIDTH]     = fifo_dout[DATA_WIDTH-1:0];
      end
    end
    if (grant_valid) begin
      rd_count_d = rd_count_q + CNT_WIDTH'(1);
      if (grant_idx == TAG_WIDTH'(FLUX - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + TAG_WIDTH'(1);
      end
      // Payload is still delivered on a mismatch; the flag is sticky.
      if (fifo_dout[WIDTH-1 -: TAG_WIDTH] != grant_idx) begin
        tag_err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q  <= '0;
      m_data_q   <= '0;
      tag_err_q  <= 1'b0;
      rd_count_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      tag_err_q  <= tag_err_d;
      rd_count_q <= rd_count_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign tag_err  = tag_err_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_sr_drain.sv
// Bench for fifo_sr_drain (FLUX=2, DATA_WIDTH=8). Captured words are tracked
// in a scoreboard queue: pushed when a grant is expected, popped after the edge.
module tb_fifo_sr_drain;

  localparam int unsigned DW = 8;
  localparam int unsigned FL = 2;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic [FL-1:0] fifo_empty;
  logic [DW:0]   fifo_dout;
  logic [FL-1:0] fifo_read;
  logic [FL-1:0] m_valid;
  logic [FL-1:0] m_ready;
  logic [FL*DW-1:0] m_data;
  logic          tag_err;
  logic [CW-1:0] rd_count;

  typedef struct {
    int unsigned flux;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [CW-1:0] exp_cnt = '0;

  fifo_sr_drain #(
    .DATA_WIDTH(DW),
    .FLUX      (FL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_read (fifo_read),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .tag_err   (tag_err),
    .rd_count  (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; fifo_empty = 2'b00; m_ready = 2'b11; fifo_dout = '0;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (fifo_read !== 2'b00) begin
        n_err++; $display("FAIL reset_read: got %b want 00", fifo_read);
      end
      n_cmp++;
      if (m_valid !== 2'b00 || m_data !== 16'h0 || tag_err !== 1'b0 || rd_count !== 16'h0) begin
        n_err++;
        $display("FAIL reset_state: got v=%b d=%h e=%b c=%0d want 0", m_valid, m_data, tag_err,
                 rd_count);
      end
      tick();
    end
    rst = 1'b0;
    fifo_empty = 2'b11;
  endtask

  task automatic test_single();
    exp_t e;
    fifo_empty = 2'b01; fifo_dout = {1'b1, 8'hA5}; m_ready = 2'b11;
    #1;
    n_cmp++;
    if (fifo_read !== 2'b10) begin
      n_err++; $display("FAIL single_read: got %b want 10", fifo_read);
    end
    sbq.push_back('{flux: 1, data: 8'hA5});
    exp_cnt++;
    tick();
    fifo_empty = 2'b11;
    e = sbq.pop_front();
    n_cmp++;
    if (m_valid !== 2'b10 || m_data[e.flux*DW +: DW] !== e.data) begin
      n_err++;
      $display("FAIL single_cap: got v=%b d=%h want v=10 d=%h", m_valid, m_data[e.flux*DW +: DW],
               e.data);
    end
    n_cmp++;
    if (rd_count !== exp_cnt) begin
      n_err++; $display("FAIL single_cnt: got %0d want %0d", rd_count, exp_cnt);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [FL-1:0] want;
    fifo_empty = 2'b00; m_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int unsigned g;
      g = (i % 2 == 0) ? 0 : 1;
      want = (g == 0) ? 2'b01 : 2'b10;
      fifo_dout = {g[0], 8'h20 + 8'(i)};
      #1;
      n_cmp++;
      if (fifo_read !== want) begin
        n_err++; $display("FAIL rr_read[%0d]: got %b want %b", i, fifo_read, want);
      end
      sbq.push_back('{flux: g, data: 8'h20 + 8'(i)});
      exp_cnt++;
      tick();
      e = sbq.pop_front();
      n_cmp++;
      if (m_valid[e.flux] !== 1'b1 || m_data[e.flux*DW +: DW] !== e.data) begin
        n_err++;
        $display("FAIL rr_cap[%0d]: got v=%b d=%h want d=%h", i, m_valid,
                 m_data[e.flux*DW +: DW], e.data);
      end
    end
    n_cmp++;
    if (rd_count !== exp_cnt || tag_err !== 1'b0) begin
      n_err++;
      $display("FAIL rr_cnt: got c=%0d e=%b want c=%0d e=0", rd_count, tag_err, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    fifo_empty = 2'b00; m_ready = 2'b11; fifo_dout = {1'b0, 8'h11};
    #1;
    n_cmp++;
    if (fifo_read !== 2'b01) begin
      n_err++; $display("FAIL bp_first: got %b want 01", fifo_read);
    end
    sbq.push_back('{flux: 0, data: 8'h11});
    exp_cnt++;
    tick();
    e = sbq.pop_front();
    m_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      exp_t e1;
      fifo_dout = {1'b1, 8'h30 + 8'(i)};
      #1;
      n_cmp++;
      if (fifo_read !== 2'b10) begin
        n_err++; $display("FAIL bp_read[%0d]: got %b want 10", i, fifo_read);
      end
      sbq.push_back('{flux: 1, data: 8'h30 + 8'(i)});
      exp_cnt++;
      tick();
      e1 = sbq.pop_front();
      n_cmp++;
      if (m_valid !== 2'b11 || m_data[7:0] !== e.data || m_data[15:8] !== e1.data) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=11 d=%h%h", i, m_valid, m_data,
                 e1.data, e.data);
      end
    end
    m_ready = 2'b11; fifo_dout = {1'b0, 8'h44};
    #1;
    n_cmp++;
    if (fifo_read !== 2'b01) begin
      n_err++; $display("FAIL bp_resume: got %b want 01", fifo_read);
    end
    sbq.push_back('{flux: 0, data: 8'h44});
    exp_cnt++;
    tick();
    e = sbq.pop_front();
    n_cmp++;
    if (m_valid[0] !== 1'b1 || m_data[7:0] !== e.data || rd_count !== exp_cnt) begin
      n_err++;
      $display("FAIL bp_cap: got v=%b d=%h c=%0d want d=%h c=%0d", m_valid, m_data[7:0],
               rd_count, e.data, exp_cnt);
    end
  endtask

  task automatic test_tag_mismatch();
    exp_t e;
    fifo_empty = 2'b10; m_ready = 2'b11; fifo_dout = {1'b1, 8'h55};
    #1;
    n_cmp++;
    if (fifo_read !== 2'b01) begin
      n_err++; $display("FAIL tag_read: got %b want 01", fifo_read);
    end
    sbq.push_back('{flux: 0, data: 8'h55});
    exp_cnt++;
    tick();
    e = sbq.pop_front();
    n_cmp++;
    if (tag_err !== 1'b1 || m_data[7:0] !== e.data) begin
      n_err++;
      $display("FAIL tag_err_set: got e=%b d=%h want e=1 d=%h", tag_err, m_data[7:0], e.data);
    end
    fifo_empty = 2'b00; fifo_dout = {1'b1, 8'h66};
    sbq.push_back('{flux: 1, data: 8'h66});
    exp_cnt++;
    tick();
    e = sbq.pop_front();
    n_cmp++;
    if (tag_err !== 1'b1 || m_data[15:8] !== e.data) begin
      n_err++;
      $display("FAIL tag_sticky: got e=%b d=%h want e=1 d=%h", tag_err, m_data[15:8], e.data);
    end
  endtask

  task automatic test_en_reset();
    exp_t e;
    // Slot 1 blocked, flux 0 only eligible.
    m_ready = 2'b00; fifo_empty = 2'b00; fifo_dout = {1'b0, 8'h77};
    sbq.push_back('{flux: 0, data: 8'h77});
    exp_cnt++;
    tick();
    e = sbq.pop_front();
    n_cmp++;
    if (m_valid !== 2'b11 || m_data[7:0] !== e.data) begin
      n_err++; $display("FAIL en_fill: got v=%b d=%h want v=11 d=%h", m_valid, m_data[7:0], e.data);
    end
    en = 1'b0;
    #1;
    n_cmp++;
    if (fifo_read !== 2'b00) begin
      n_err++; $display("FAIL en_off_read: got %b want 00", fifo_read);
    end
    m_ready = 2'b11;
    tick();
    n_cmp++;
    if (m_valid !== 2'b00 || rd_count !== exp_cnt) begin
      n_err++;
      $display("FAIL en_off_drain: got v=%b c=%0d want v=00 c=%0d", m_valid, rd_count, exp_cnt);
    end
    en = 1'b1; m_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      int unsigned g;
      g = (i == 0) ? 1 : 0;
      fifo_dout = {g[0], 8'h88 + 8'(i)};
      sbq.push_back('{flux: g, data: 8'h88 + 8'(i)});
      exp_cnt++;
      tick();
      e = sbq.pop_front();
      n_cmp++;
      if (m_valid[e.flux] !== 1'b1 || m_data[e.flux*DW +: DW] !== e.data) begin
        n_err++;
        $display("FAIL rst_fill[%0d]: got v=%b d=%h want d=%h", i, m_valid,
                 m_data[e.flux*DW +: DW], e.data);
      end
    end
    n_cmp++;
    if (m_valid !== 2'b11) begin
      n_err++; $display("FAIL rst_pre: got v=%b want 11", m_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (fifo_read !== 2'b00) begin
      n_err++; $display("FAIL rst_read: got %b want 00", fifo_read);
    end
    tick();
    sbq.delete();
    n_cmp++;
    if (m_valid !== 2'b00 || rd_count !== 16'h0 || tag_err !== 1'b0 || m_data !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mid: got v=%b c=%0d e=%b d=%h want all 0", m_valid, rd_count, tag_err,
               m_data);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fifo_empty = 2'b11; fifo_dout = '0; m_ready = 2'b00;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_tag_mismatch();
    test_en_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
